key_scanner: RTL and testbench

- Front end for all front-panel switches and buttons.
- Synchronises and debounces raw note keys, length keys, submit, cancel, oct_up and oct_down.
- Produces clean levels, single-cycle press pulses and a one-hot held-note code.
- Sits between board pins and the piano controller/mode blocks, replacing ad-hoc per-button pulse generators with one shared producer of key events.

---
 rtl/key_scanner.sv | 130 +++++++++++++
 tb/tb_key_scanner.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/key_scanner.sv
// key_scanner: synchronises and debounces every front-panel input, then emits levels, press pulses and a one-hot held note.
// Define KEY_REPEAT_EN to enable auto-repeat pulses on oct_up/oct_down.
module key_scanner #(
  parameter int DEBOUNCE_CYCLES = 2000000,
  parameter int NOTE_KEYS       = 7,
  parameter int LENGTH_KEYS     = 7,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NOTE_KEYS-1:0]   raw_note,
  input  logic [LENGTH_KEYS-1:0] raw_length,
  input  logic                   raw_submit,
  input  logic                   raw_cancel,
  input  logic                   raw_oct_up,
  input  logic                   raw_oct_down,
  output logic [NOTE_KEYS-1:0]   note_key,
  output logic                   note_press,
  output logic                   note_release,
  output logic [LENGTH_KEYS-1:0] length_key,
  output logic                   submit_p,
  output logic                   cancel_p,
  output logic                   oct_up_p,
  output logic                   oct_down_p,
  output logic                   multi_key
);
  localparam int N  = NOTE_KEYS + LENGTH_KEYS + 4;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, HELD, LOCK} state_t;
  state_t state, state_n;
  logic [N-1:0] raw, s1, s2, stable, stable_d;
  logic [CW-1:0] cnt [N];
  logic [NOTE_KEYS-1:0] s_note, key_n;
  logic [3:0] btn, rise;
  logic [1:0] rep;
  logic one_hot, press_n, rel_n;
  assign raw = {raw_oct_down, raw_oct_up, raw_cancel, raw_submit, raw_length, raw_note};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      stable <= '0;
      stable_d <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      stable_d <= stable;
      for (int i = 0; i < N; i++)
        if (s2[i] == stable[i]) cnt[i] <= '0;
        else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          stable[i] <= s2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + CW'(1);
    end
  assign s_note  = stable[NOTE_KEYS-1:0];
  assign btn     = stable[N-1:N-4];
  assign rise    = btn & ~stable_d[N-1:N-4];
  assign one_hot = |s_note && ~|(s_note & (s_note - {{(NOTE_KEYS-1){1'b0}}, 1'b1}));
`ifdef KEY_REPEAT_EN
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  logic [RW-1:0] rcnt [2];
  logic [1:0] armed, hold;
  // an oct key only repeats while it is held alone
  assign hold = {btn[3] & ~btn[2], btn[2] & ~btn[3]};
  always_comb
    for (int i = 0; i < 2; i++)
      rep[i] = hold[i] && rcnt[i] == (armed[i] ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      armed <= '0;
      for (int i = 0; i < 2; i++) rcnt[i] <= '0;
    end else
      for (int i = 0; i < 2; i++)
        if (!hold[i]) begin
          rcnt[i] <= '0;
          armed[i] <= 1'b0;
        end else if (rep[i]) begin
          rcnt[i] <= RW'(1);
          armed[i] <= 1'b1;
        end else rcnt[i] <= rcnt[i] + RW'(1);
`else
  assign rep = '0;
`endif
  always_comb begin
    state_n = state;
    key_n   = note_key;
    press_n = 1'b0;
    rel_n   = 1'b0;
    case (state)
      IDLE: if (one_hot) begin
        state_n = HELD;
        key_n   = s_note;
        press_n = 1'b1;
      end else if (|s_note) state_n = LOCK;
      HELD: if (~|(s_note & note_key)) begin
        key_n   = '0;
        rel_n   = 1'b1;
        state_n = |s_note ? LOCK : IDLE;
      end
      LOCK: if (~|s_note) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign multi_key = state == LOCK;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      note_key <= '0;
      note_press <= 1'b0;
      note_release <= 1'b0;
      length_key <= '0;
      submit_p <= 1'b0;
      cancel_p <= 1'b0;
      oct_up_p <= 1'b0;
      oct_down_p <= 1'b0;
    end else begin
      state <= state_n;
      note_key <= key_n;
      note_press <= press_n;
      note_release <= rel_n;
      length_key <= stable[NOTE_KEYS+LENGTH_KEYS-1:NOTE_KEYS];
      submit_p <= rise[0] & ~rise[1];
      cancel_p <= rise[1];
      oct_up_p <= (rise[2] & ~rise[3]) | rep[0];
      oct_down_p <= (rise[3] & ~rise[2]) | rep[1];
    end
endmodule

// File: tb/tb_key_scanner.sv
// tb_key_scanner: directed checks of key_scanner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
module tb_key_scanner;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [6:0] raw_note = '0, raw_length = '0;
  logic raw_submit = 1'b0, raw_cancel = 1'b0, raw_oct_up = 1'b0, raw_oct_down = 1'b0;
  logic [6:0] note_key, length_key;
  logic note_press, note_release, submit_p, cancel_p, oct_up_p, oct_down_p, multi_key;
  logic [20:0] outs;
  int tests = 0, fails = 0;
  logic acc;
  key_scanner #(.DEBOUNCE_CYCLES(4), .NOTE_KEYS(7), .LENGTH_KEYS(7), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)) dut (
    .clk(clk), .rst_n(rst_n), .raw_note(raw_note), .raw_length(raw_length),
    .raw_submit(raw_submit), .raw_cancel(raw_cancel), .raw_oct_up(raw_oct_up), .raw_oct_down(raw_oct_down),
    .note_key(note_key), .note_press(note_press), .note_release(note_release), .length_key(length_key),
    .submit_p(submit_p), .cancel_p(cancel_p), .oct_up_p(oct_up_p), .oct_down_p(oct_down_p), .multi_key(multi_key)
  );
  assign outs = {note_key, note_press, note_release, length_key, submit_p, cancel_p, oct_up_p, oct_down_p, multi_key};
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    tick(3);
    chk("reset_outs", 32'(outs), 0);
    rst_n = 1'b1;
    tick(2);
    raw_submit = 1'b1;
    tick(6);
    chk("submit_early", 32'(submit_p), 0);
    tick(1);
    chk("submit_pulse", 32'(submit_p), 1);
    chk("submit_others", 32'({outs[20:5], outs[3:0]}), 0);
    tick(1);
    chk("submit_single", 32'(submit_p), 0);
    tick(1);
    raw_submit = 1'b0;
    acc = 1'b0;
    for (int i = 0; i < 12; i++) begin tick(1); acc |= submit_p; end
    chk("submit_release_no_pulse", 32'(acc), 0);
    raw_note = 7'b0000100;
    tick(3);
    raw_note = '0;
    acc = 1'b0;
    for (int i = 0; i < 12; i++) begin tick(1); acc |= (|note_key) | note_press | note_release; end
    chk("glitch_ignored", 32'(acc), 0);
    raw_note = 7'b0000100;
    tick(7);
    chk("held_key", 32'(note_key), 32'h04);
    chk("held_press", 32'(note_press), 1);
    tick(1);
    chk("held_press_single", 32'(note_press), 0);
    raw_note = 7'b0000101;
    tick(8);
    chk("held_add_key", 32'(note_key), 32'h04);
    chk("held_add_multi", 32'(multi_key), 0);
    raw_note = 7'b0000001;
    tick(6);
    chk("held_before_rel", 32'(note_key), 32'h04);
    tick(1);
    chk("rel_key", 32'(note_key), 0);
    chk("rel_pulse", 32'(note_release), 1);
    chk("rel_lock", 32'(multi_key), 1);
    tick(1);
    chk("rel_single", 32'(note_release), 0);
    raw_note = '0;
    tick(6);
    chk("lock_kept", 32'(multi_key), 1);
    tick(1);
    chk("lock_exit", 32'(multi_key), 0);
    raw_note = 7'b0010001;
    tick(7);
    chk("multi_lock", 32'(multi_key), 1);
    chk("multi_key0", 32'(note_key), 0);
    chk("multi_press0", 32'(note_press), 0);
    raw_note = '0;
    acc = 1'b0;
    for (int i = 0; i < 7; i++) begin tick(1); acc |= note_press | note_release | (|note_key); end
    chk("multi_no_pulses", 32'(acc), 0);
    chk("multi_exit", 32'(multi_key), 0);
    raw_submit = 1'b1;
    raw_cancel = 1'b1;
    tick(7);
    chk("conflict_cancel", 32'(cancel_p), 1);
    chk("conflict_submit", 32'(submit_p), 0);
    raw_submit = 1'b0;
    raw_cancel = 1'b0;
    tick(10);
    raw_oct_up = 1'b1;
    raw_oct_down = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(1); acc |= oct_up_p | oct_down_p; end
    chk("oct_conflict", 32'(acc), 0);
    raw_oct_up = 1'b0;
    raw_oct_down = 1'b0;
    tick(10);
    raw_oct_down = 1'b1;
    tick(7);
    chk("oct_down_pulse", 32'(oct_down_p), 1);
    raw_oct_down = 1'b0;
    raw_length = 7'h55;
    tick(6);
    chk("length_early", 32'(length_key), 0);
    tick(1);
    chk("length_level", 32'(length_key), 32'h55);
    raw_length = '0;
    tick(10);
    raw_note = 7'b0000010;
    tick(8);
    chk("pre_reset_key", 32'(note_key), 32'h02);
    raw_submit = 1'b1;
    tick(3);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outs", 32'(outs), 0);
    tick(2);
    chk("reset_no_release", 32'(outs), 0);
    rst_n = 1'b1;
    tick(6);
    chk("post_reset_early", 32'({note_key, submit_p}), 0);
    tick(1);
    chk("post_reset_submit", 32'(submit_p), 1);
    chk("post_reset_key", 32'(note_key), 32'h02);
    chk("post_reset_press", 32'(note_press), 1);
    raw_submit = 1'b0;
    raw_note = '0;
    tick(12);
    raw_oct_up = 1'b1;
    for (int i = 1; i <= 45; i++) begin
      tick(1);
`ifdef KEY_REPEAT_EN
      chk($sformatf("repeat_%0d", i), 32'(oct_up_p), 32'(i == 7 || i == 27 || i == 35 || i == 43));
`else
      chk($sformatf("repeat_%0d", i), 32'(oct_up_p), 32'(i == 7));
`endif
      if (i == 40) raw_oct_up = 1'b0;
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
